// File: rtl/uart2bus_pkg.sv
// Shared types and constants for the UART receiver and the downstream command parser.
// The parser matches incoming bytes against the ASCII constants held here.
package uart2bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rxState_t;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_SAMPLE = 4'd7;
   localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

   localparam logic [7:0] ASCII_R_UPPER = 8'h52;
   localparam logic [7:0] ASCII_R_LOWER = 8'h72;
   localparam logic [7:0] ASCII_W_UPPER = 8'h57;
   localparam logic [7:0] ASCII_W_LOWER = 8'h77;
   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_TAB     = 8'h09;
   localparam logic [7:0] ASCII_LF      = 8'h0A;
   localparam logic [7:0] ASCII_CR      = 8'h0D;

endpackage

// File: rtl/baud_gen.sv
// Fractional baud accumulator producing a one-cycle ce16 tick at 16x the bit rate.
// Tick rate is clock * baud_freq / baud_limit.
module baud_gen (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] baud_freq,
   input  logic [15:0] baud_limit,
   output logic        ce16
);

   logic [15:0] accQ, accD;
   logic [16:0] sum;

   // A zero increment freezes the accumulator and suppresses ticks entirely.
   always_comb begin
      sum  = {1'b0, accQ} + {5'b0, baud_freq};
      accD = sum[15:0];
      ce16 = 1'b0;
      if ((baud_freq != 12'd0) && (sum >= {1'b0, baud_limit})) begin
         accD = 16'(sum - {1'b0, baud_limit});
         ce16 = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         accQ <= '0;
      end else begin
         accQ <= accD;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, input synchronizer and framing-error detection.
// rx_data only ever holds a byte whose stop bit was sampled high.
module uart_rx
   import uart2bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ser_in,
   input  logic [11:0] baud_freq,
   input  logic [15:0] baud_limit,
   output logic [7:0]  rx_data,
   output logic        new_rx_data,
   output logic        frame_err,
   output logic        rx_busy
);

   logic                   ce16;
   logic [SYNC_STAGES-1:0] syncQ;
   logic                   rxBit;

   rxState_t   stateQ, stateD;
   logic [3:0] cntQ, cntD;
   logic [2:0] bitIdxQ, bitIdxD;
   logic [7:0] shiftQ, shiftD;
   logic [7:0] rxDataQ, rxDataD;
   logic       newRxDataQ, newRxDataD;
   logic       frameErrQ, frameErrD;

   baud_gen uBaudGen (
      .clock      (clock),
      .reset      (reset),
      .baud_freq  (baud_freq),
      .baud_limit (baud_limit),
      .ce16       (ce16)
   );

   assign rxBit = syncQ[SYNC_STAGES-1];

   // Start is checked mid-bit to reject glitches; data and stop bits are sampled one full bit later each.
   always_comb begin
      stateD     = stateQ;
      cntD       = cntQ;
      bitIdxD    = bitIdxQ;
      shiftD     = shiftQ;
      rxDataD    = rxDataQ;
      newRxDataD = 1'b0;
      frameErrD  = 1'b0;
      case (stateQ)
         IDLE: begin
            if (!rxBit) begin
               stateD = START;
               cntD   = '0;
            end
         end
         START: begin
            if (ce16) begin
               if (cntQ == MID_SAMPLE) begin
                  if (rxBit) begin
                     stateD = IDLE;
                  end else begin
                     stateD  = DATA;
                     cntD    = '0;
                     bitIdxD = '0;
                  end
               end else begin
                  cntD = cntQ + 4'd1;
               end
            end
         end
         DATA: begin
            if (ce16) begin
               cntD = cntQ + 4'd1;
               if (cntQ == LAST_TICK) begin
                  shiftD  = {rxBit, shiftQ[7:1]};
                  bitIdxD = bitIdxQ + 3'd1;
                  if (bitIdxQ == 3'd7) begin
                     stateD = STOP;
                     cntD   = '0;
                  end
               end
            end
         end
         STOP: begin
            if (ce16) begin
               if (cntQ == LAST_TICK) begin
                  if (rxBit) begin
                     rxDataD    = shiftQ;
                     newRxDataD = 1'b1;
                     stateD     = IDLE;
                  end else begin
                     frameErrD = 1'b1;
                     stateD    = WAIT_HIGH;
                  end
               end else begin
                  cntD = cntQ + 4'd1;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxBit) begin
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         syncQ      <= '1;
         stateQ     <= IDLE;
         cntQ       <= '0;
         bitIdxQ    <= '0;
         shiftQ     <= '0;
         rxDataQ    <= '0;
         newRxDataQ <= 1'b0;
         frameErrQ  <= 1'b0;
      end else begin
         syncQ      <= {syncQ[SYNC_STAGES-2:0], ser_in};
         stateQ     <= stateD;
         cntQ       <= cntD;
         bitIdxQ    <= bitIdxD;
         shiftQ     <= shiftD;
         rxDataQ    <= rxDataD;
         newRxDataQ <= newRxDataD;
         frameErrQ  <= frameErrD;
      end
   end

   assign rx_data     = rxDataQ;
   assign new_rx_data = newRxDataQ;
   assign frame_err   = frameErrQ;
   assign rx_busy     = (stateQ != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, glitches, framing errors, back-to-back frames,
// mid-frame reset and a real 115200-baud rate setting with clock skew.
module tb_uart_rx;

   logic        clock;
   logic        reset;
   logic        serIn;
   logic [11:0] baudFreq;
   logic [15:0] baudLimit;
   logic [7:0]  rxData;
   logic        newRxData;
   logic        frameErr;
   logic        rxBusy;

   int checkCount   = 0;
   int passCount    = 0;
   int failCount    = 0;
   int strobeCount  = 0;
   int ferrCount    = 0;
   int overlapCount = 0;
   logic [7:0] rxLog[$];

   int baseStrobe;
   int baseFerr;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .ser_in      (serIn),
      .baud_freq   (baudFreq),
      .baud_limit  (baudLimit),
      .rx_data     (rxData),
      .new_rx_data (newRxData),
      .frame_err   (frameErr),
      .rx_busy     (rxBusy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Outputs are observed on the falling edge, half a cycle clear of the register updates.
   always @(negedge clock) begin
      if (newRxData) begin
         strobeCount++;
         rxLog.push_back(rxData);
      end
      if (frameErr) ferrCount++;
      if (newRxData && frameErr) overlapCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic value, input int clocks);
      serIn = value;
      repeat (clocks) @(negedge clock);
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int bitClocks);
      applyStimulus(1'b0, bitClocks);
      for (int i = 0; i < 8; i++) applyStimulus(data[i], bitClocks);
      applyStimulus(stopBit, bitClocks);
   endtask

   function automatic logic [7:0] logAt(input int idx);
      if (idx < rxLog.size()) return rxLog[idx];
      return 8'hXX;
   endfunction

   initial begin
      logic [7:0] partial;
      reset     = 1'b1;
      serIn     = 1'b1;
      baudFreq  = 12'd1;
      baudLimit = 16'd1;
      repeat (3) @(negedge clock);

      $display("[TB] reset state");
      checkOutput("reset_rx_data", 32'(rxData), 32'h00);
      checkOutput("reset_new_rx_data", 32'(newRxData), 32'h0);
      checkOutput("reset_frame_err", 32'(frameErr), 32'h0);
      checkOutput("reset_rx_busy", 32'(rxBusy), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      $display("[TB] single frame 0x52 at 16 clocks/bit");
      baseStrobe = strobeCount;
      baseFerr   = ferrCount;
      sendFrame(8'h52, 1'b1, 16);
      repeat (10) @(negedge clock);
      checkOutput("t1_busy_low_by_170", 32'(rxBusy), 32'h0);
      checkOutput("t1_strobe_count", 32'(strobeCount - baseStrobe), 32'd1);
      checkOutput("t1_strobe_data", 32'(logAt(baseStrobe)), 32'h52);
      checkOutput("t1_rx_data_held", 32'(rxData), 32'h52);
      checkOutput("t1_no_frame_err", 32'(ferrCount - baseFerr), 32'd0);
      repeat (10) @(negedge clock);

      $display("[TB] 4-clock glitch on the line");
      baseStrobe = strobeCount;
      applyStimulus(1'b0, 4);
      applyStimulus(1'b1, 2);
      checkOutput("t2_busy_in_start", 32'(rxBusy), 32'h1);
      repeat (6) @(negedge clock);
      checkOutput("t2_busy_low_by_12", 32'(rxBusy), 32'h0);
      repeat (30) @(negedge clock);
      checkOutput("t2_no_strobe", 32'(strobeCount - baseStrobe), 32'd0);

      $display("[TB] framing error with line held low");
      baseStrobe = strobeCount;
      baseFerr   = ferrCount;
      sendFrame(8'h52, 1'b1, 16);
      sendFrame(8'h77, 1'b0, 16);
      applyStimulus(1'b0, 200);
      checkOutput("t3_one_frame_err", 32'(ferrCount - baseFerr), 32'd1);
      checkOutput("t3_only_first_strobe", 32'(strobeCount - baseStrobe), 32'd1);
      checkOutput("t3_rx_data_kept", 32'(rxData), 32'h52);
      checkOutput("t3_busy_wait_high", 32'(rxBusy), 32'h1);
      applyStimulus(1'b1, 20);
      checkOutput("t3_idle_after_high", 32'(rxBusy), 32'h0);
      checkOutput("t3_no_strobe_on_release", 32'(strobeCount - baseStrobe), 32'd1);
      sendFrame(8'h57, 1'b1, 16);
      applyStimulus(1'b1, 20);
      checkOutput("t3_recover_count", 32'(strobeCount - baseStrobe), 32'd2);
      checkOutput("t3_recover_data", 32'(rxData), 32'h57);

      $display("[TB] back-to-back frames");
      baseStrobe = strobeCount;
      sendFrame(8'h52, 1'b1, 16);
      sendFrame(8'h20, 1'b1, 16);
      sendFrame(8'h0A, 1'b1, 16);
      applyStimulus(1'b1, 20);
      checkOutput("t4_strobe_count", 32'(strobeCount - baseStrobe), 32'd3);
      checkOutput("t4_byte0", 32'(logAt(baseStrobe)), 32'h52);
      checkOutput("t4_byte1", 32'(logAt(baseStrobe + 1)), 32'h20);
      checkOutput("t4_byte2", 32'(logAt(baseStrobe + 2)), 32'h0A);

      $display("[TB] reset during data bit 4 of 0x57");
      baseStrobe = strobeCount;
      partial = 8'h57;
      applyStimulus(1'b0, 16);
      for (int i = 0; i < 4; i++) applyStimulus(partial[i], 16);
      applyStimulus(partial[4], 8);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("t5_reset_rx_data", 32'(rxData), 32'h00);
      checkOutput("t5_reset_new_rx_data", 32'(newRxData), 32'h0);
      checkOutput("t5_reset_frame_err", 32'(frameErr), 32'h0);
      checkOutput("t5_reset_rx_busy", 32'(rxBusy), 32'h0);
      serIn = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      applyStimulus(1'b1, 200);
      checkOutput("t5_partial_discarded", 32'(strobeCount - baseStrobe), 32'd0);
      sendFrame(8'h0D, 1'b1, 16);
      applyStimulus(1'b1, 20);
      checkOutput("t5_strobe_count", 32'(strobeCount - baseStrobe), 32'd1);
      checkOutput("t5_rx_data", 32'(rxData), 32'h0D);

      $display("[TB] 115200 baud at 40 MHz with -2%% and +2%% skew");
      baudFreq  = 12'd144;
      baudLimit = 16'd3125;
      baseFerr  = ferrCount;
      baseStrobe = strobeCount;
      sendFrame(8'h57, 1'b1, 340);
      applyStimulus(1'b1, 100);
      checkOutput("t6_fast_rx_data", 32'(logAt(baseStrobe)), 32'h57);
      sendFrame(8'h57, 1'b1, 354);
      applyStimulus(1'b1, 100);
      checkOutput("t6_slow_rx_data", 32'(logAt(baseStrobe + 1)), 32'h57);
      checkOutput("t6_strobe_count", 32'(strobeCount - baseStrobe), 32'd2);
      checkOutput("t6_no_frame_err", 32'(ferrCount - baseFerr), 32'd0);

      checkOutput("strobe_err_exclusive", 32'(overlapCount), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of ser_in synchronizer flops (minimum 2).
REQ-002 SHALL have port clock  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ser_in  in  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 SHALL have port baud_freq  in  12  baud accumulator increment.
REQ-006 SHALL have port baud_limit  in  16  baud accumulator modulus.
REQ-007 SHALL have port rx_data  out  8  last correctly framed byte.
REQ-008 SHALL have port new_rx_data  out  1  one-cycle strobe; rx_data valid on that cycle and held after it.
REQ-009 SHALL have port frame_err  out  1  one-cycle strobe on a bad stop bit.
REQ-010 SHALL have port rx_busy  out  1  high whenever FSM is not IDLE.

Function
REQ-011 SHALL pass ser_in through SYNC_STAGES flops (reset value 1); FSM uses only the synchronized bit.
REQ-012 SHALL compute a 17-bit sum = acc + baud_freq per clock: if sum >= baud_limit, acc <= sum - baud_limit and ce16 = 1 for one cycle; else acc <= sum, ce16 = 0 (16x tick rate = clock*baud_freq/baud_limit).
REQ-013 SHALL stall all bit timing while baud_freq = 0 (no ce16); baud_freq/baud_limit changes take effect on the next clock with no mid-frame protection.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: synchronized line 0 -> START, 4-bit tick counter cnt <= 0.
REQ-016 START: cnt increments on ce16; on the ce16 with cnt = 7, sample line: 1 -> IDLE (glitch, no strobe); 0 -> DATA, cnt <= 0, bit index <= 0.
REQ-017 DATA: on the ce16 with cnt = 15, shift the sampled bit in at MSB (LSB-first assembly) and increment bit index; after the 8th bit -> STOP, cnt <= 0.
REQ-018 STOP: on the ce16 with cnt = 15, sample: 1 -> rx_data <= shift register, new_rx_data = 1 next cycle, -> IDLE; 0 -> frame_err = 1 next cycle, rx_data unchanged, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until synchronized line = 1, then -> IDLE (break/held-low line never produces a byte).
REQ-020 new_rx_data and frame_err SHALL never be high in the same cycle.
REQ-021 Back-to-back frames: a start edge present on the cycle IDLE is re-entered SHALL be accepted with no lost byte.

Reset
REQ-022 SHALL, on reset = 1, asynchronously force: FSM IDLE, acc 0, cnt 0, bit index 0, shift 0, synchronizer flops 1, rx_data 0x00, new_rx_data 0, frame_err 0, rx_busy 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte with no strobe; reception restarts on the first start edge after release.

Structure
REQ-024 Package uart2bus_pkg SHALL hold the FSM state enum, OVERSAMPLE = 16, MID_SAMPLE = 7, and the protocol ASCII constants (0x52 'R', 0x72 'r', 0x57 'W', 0x77 'w', 0x20 space, 0x09 tab, 0x0A, 0x0D) shared with the downstream command parser.
REQ-025 The accumulator of REQ-012 SHALL be a sub-module baud_gen (ports clock, reset, baud_freq, baud_limit, ce16).

Verification
REQ-026 baud_freq=1, baud_limit=1 (16 clocks/bit), send 0x52 -> exactly one new_rx_data pulse, rx_data=0x52, frame_err stays 0, rx_busy low within 170 clocks of start edge.
REQ-027 Same rates, ser_in low for 4 clocks then high -> no strobe, FSM back to IDLE, rx_busy low by clock 12.
REQ-028 Send 0x52 then 0x77 with stop bit 0, line held low 200 clocks -> one frame_err pulse, rx_data stays 0x52, no new_rx_data until line returns high and a new frame arrives.
REQ-029 Back-to-back 0x52, 0x20, 0x0A (one stop bit each, no gap) -> three new_rx_data pulses in order with matching rx_data.
REQ-030 Assert reset during data bit 4 of 0x57, release, send 0x0D -> all outputs 0 during reset, single strobe with rx_data=0x0D afterwards.
REQ-031 baud_freq=144, baud_limit=3125 (115200 baud at 40 MHz), send 0x57 at true 115200 timing (+/-2% skew) -> rx_data=0x57, frame_err 0.
